regfl_arb_ctrl: RTL and testbench

Two-requester controller for the 4x8 register file: arbitrates round-robin between requester 0 and requester 1, sequences WRITE, READ, INC (read-modify-write) and CLR operations onto the file's single write port and single read port, and returns read data with a one-cycle acknowledge pulse. Sits between two client blocks and the register file. Only this controller drives the file's ports.

---
 rtl/regfl_arb_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_regfl_arb_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfl_arb_ctrl.sv
// Two-requester round-robin controller for a small register file.
// Runs WRITE/READ/INC/CLR operations and returns read data with a one-cycle ack.
module regfl_arb_ctrl #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  input  logic [AW-1:0]    addr0,
  input  logic [AW-1:0]    addr1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1,
  output logic             busy,
  output logic             rf_wr_e,
  output logic [AW-1:0]    rf_wr_addr,
  output logic [WIDTH-1:0] rf_wr_data,
  output logic [AW-1:0]    rf_rd_addr,
  input  logic [WIDTH-1:0] rf_rd_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_INC   = 2'b10;
  localparam logic [1:0] OP_CLR   = 2'b11;

  state_t           state_reg, state_next;
  logic             ptr_reg, ptr_next;
  logic             grant_reg, grant_next;
  logic [1:0]       op_reg, op_next;
  logic [AW-1:0]    addr_reg, addr_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic [WIDTH-1:0] temp_reg, temp_next;
  logic [WIDTH-1:0] rdata_reg [2];

  logic [1:0]       req_vec;
  logic [1:0]       op_vec   [2];
  logic [AW-1:0]    addr_vec [2];
  logic [WIDTH-1:0] data_vec [2];
  logic             win;
  logic [1:0]       rdata_load;
  logic [WIDTH-1:0] rdata_val;
  logic [WIDTH-1:0] inc_val;
  logic [1:0]       ack_vec;

  assign req_vec     = {req1, req0};
  assign op_vec[0]   = op0;
  assign op_vec[1]   = op1;
  assign addr_vec[0] = addr0;
  assign addr_vec[1] = addr1;
  assign data_vec[0] = data0;
  assign data_vec[1] = data1;

  // Contention goes to the pointer; a lone request wins outright.
  always_comb begin
    if (req_vec == 2'b11) win = ptr_reg;
    else                  win = req_vec[1];
  end

  // Wraps modulo 2^WIDTH by truncation.
  assign inc_val = temp_reg + {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    grant_next = grant_reg;
    op_next    = op_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    temp_next  = temp_reg;
    rf_wr_e    = 1'b0;
    rf_wr_data = '0;
    rdata_load = 2'b00;
    rdata_val  = '0;
    case (state_reg)
      IDLE: begin
        if (|req_vec) begin
          grant_next = win;
          ptr_next   = ~win;
          op_next    = op_vec[win];
          addr_next  = addr_vec[win];
          data_next  = data_vec[win];
          state_next = EXEC;
        end
      end
      EXEC: begin
        case (op_reg)
          OP_WRITE: begin
            rf_wr_e    = 1'b1;
            rf_wr_data = data_reg;
            state_next = DONE;
          end
          OP_CLR: begin
            rf_wr_e    = 1'b1;
            state_next = DONE;
          end
          OP_READ: begin
            rdata_load[grant_reg] = 1'b1;
            rdata_val             = rf_rd_data;
            state_next            = DONE;
          end
          OP_INC: begin
            temp_next  = rf_rd_data;
            state_next = WB;
          end
          default: state_next = DONE;
        endcase
      end
      WB: begin
        rf_wr_e               = 1'b1;
        rf_wr_data            = inc_val;
        rdata_load[grant_reg] = 1'b1;
        rdata_val             = inc_val;
        state_next            = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= 1'b0;
      grant_reg <= 1'b0;
      op_reg    <= OP_WRITE;
      addr_reg  <= '0;
      data_reg  <= '0;
      temp_reg  <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      grant_reg <= grant_next;
      op_reg    <= op_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      temp_reg  <= temp_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) rdata_reg[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (rdata_load[i]) rdata_reg[i] <= rdata_val;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ack
      assign ack_vec[gi] = (state_reg == DONE) && (grant_reg == 1'(gi));
    end
  endgenerate

  assign ack0       = ack_vec[0];
  assign ack1       = ack_vec[1];
  assign rdata0     = rdata_reg[0];
  assign rdata1     = rdata_reg[1];
  assign busy       = (state_reg != IDLE);
  assign rf_wr_addr = addr_reg;
  assign rf_rd_addr = addr_reg;

endmodule

// File: tb/tb_regfl_arb_ctrl.sv
// Directed bench for regfl_arb_ctrl with a behavioural register file,
// reference memory model and per-requester scoreboards checked on each ack.
module tb_regfl_arb_ctrl;
  localparam int WIDTH = 8;
  localparam int AW    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       req_d  [2] = '{default: 1'b0};
  logic [1:0] op_d   [2] = '{default: 2'b00};
  logic [1:0] addr_d [2] = '{default: 2'b00};
  logic [7:0] data_d [2] = '{default: 8'h00};

  logic       ack0, ack1, busy, rf_wr_e;
  logic [7:0] rdata0, rdata1, rf_wr_data, rf_rd_data;
  logic [1:0] rf_wr_addr, rf_rd_addr;

  regfl_arb_ctrl #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req0(req_d[0]), .req1(req_d[1]),
    .op0(op_d[0]), .op1(op_d[1]),
    .addr0(addr_d[0]), .addr1(addr_d[1]),
    .data0(data_d[0]), .data1(data_d[1]),
    .ack0(ack0), .ack1(ack1),
    .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy),
    .rf_wr_e(rf_wr_e), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data)
  );

  // Register file model: combinational read, write on rising edge.
  logic [7:0] rf_mem [4] = '{default: 8'h00};
  always @(posedge clk) if (rf_wr_e) rf_mem[rf_wr_addr] <= rf_wr_data;
  assign rf_rd_data = rf_mem[rf_rd_addr];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  typedef struct {
    logic [7:0] rdata;
    int         lat;
    int         issue;
    string      name;
  } exp_t;

  exp_t       sb0[$];
  exp_t       sb1[$];
  int         ack_log[$];
  logic [7:0] ref_mem   [4] = '{default: 8'h00};
  logic [7:0] ref_rdata [2] = '{default: 8'h00};

  // Update the reference model, push the expectation, drive the request and wait for ack.
  // lat < 0 marks a request whose latency depends on the other requester.
  task automatic run_op(input int id, input logic [1:0] op, input logic [1:0] addr,
                        input logic [7:0] data, input int lat, input string name);
    exp_t e;
    bit   got;
    case (op)
      2'b00: ref_mem[addr] = data;
      2'b01: ref_rdata[id] = ref_mem[addr];
      2'b10: begin
        ref_mem[addr] = ref_mem[addr] + 8'd1;
        ref_rdata[id] = ref_mem[addr];
      end
      default: ref_mem[addr] = 8'h00;
    endcase
    e.rdata = ref_rdata[id];
    e.lat   = lat;
    e.issue = cyc;
    e.name  = name;
    if (id == 0) sb0.push_back(e);
    else         sb1.push_back(e);
    req_d[id]  = 1'b1;
    op_d[id]   = op;
    addr_d[id] = addr;
    data_d[id] = data;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = (id == 0) ? ack0 : ack1;
    end
    req_d[id] = 1'b0;
    check({name, "_ack_seen"}, 32'(got), 1);
    if (lat >= 0) @(negedge clk);
  endtask

  task automatic handle_ack(input int id, input logic [7:0] rd, input logic prev);
    exp_t e;
    int   n;
    ack_log.push_back(id);
    check("ack_one_cycle", 32'(prev), 0);
    n = (id == 0) ? sb0.size() : sb1.size();
    check("ack_expected", 32'(n > 0), 1);
    if (n > 0) begin
      if (id == 0) e = sb0.pop_front();
      else         e = sb1.pop_front();
      check({e.name, "_rdata"}, 32'(rd), 32'(e.rdata));
      if (e.lat >= 0) check({e.name, "_latency"}, cyc - e.issue, e.lat);
    end
  endtask

  logic prev0 = 1'b0;
  logic prev1 = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (ack0 || ack1) check("ack_exclusive", 32'(ack0 & ack1), 0);
      if (ack0) handle_ack(0, rdata0, prev0);
      if (ack1) handle_ack(1, rdata1, prev1);
    end
    prev0 = ack0;
    prev1 = ack1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_ack0", 32'(ack0), 0);
    check("rst_ack1", 32'(ack1), 0);
    check("rst_rdata0", 32'(rdata0), 0);
    check("rst_rdata1", 32'(rdata1), 0);
    check("rst_wr_e", 32'(rf_wr_e), 0);
    check("rst_wr_addr", 32'(rf_wr_addr), 0);
    check("rst_wr_data", 32'(rf_wr_data), 0);
    check("rst_rd_addr", 32'(rf_rd_addr), 0);

    // Simultaneous writes at reset release: requester 0 first, requester 1 one full op later.
    rst = 1'b0;
    ack_log.delete();
    fork
      run_op(0, 2'b00, 2'd0, 8'hA2, 2, "cont_w0");
      run_op(1, 2'b00, 2'd1, 8'h55, 5, "cont_w1");
    join
    check("cont_first", 32'(ack_log.size() > 0 ? ack_log[0] : 9), 0);
    check("cont_second", 32'(ack_log.size() > 1 ? ack_log[1] : 9), 1);
    check("cont_rf0", 32'(rf_mem[0]), 'hA2);
    check("cont_rf1", 32'(rf_mem[1]), 'h55);
    check("idle_busy", 32'(busy), 0);

    run_op(0, 2'b01, 2'd3, 8'h00, 2, "rd_unwritten");
    run_op(0, 2'b00, 2'd2, 8'h2E, 2, "wr_a2");
    run_op(0, 2'b01, 2'd2, 8'h00, 2, "rd_a2");

    run_op(0, 2'b00, 2'd1, 8'hFF, 2, "wr_ff");
    run_op(1, 2'b10, 2'd1, 8'h00, 3, "inc_wrap");
    check("inc_wrap_rf", 32'(rf_mem[1]), 'h00);
    run_op(1, 2'b01, 2'd1, 8'h00, 2, "rd_wrap");
    run_op(0, 2'b00, 2'd2, 8'h7F, 2, "wr_7f");
    run_op(0, 2'b10, 2'd2, 8'h00, 3, "inc_7f");
    check("inc_7f_rf", 32'(rf_mem[2]), 'h80);

    run_op(0, 2'b00, 2'd3, 8'hC7, 2, "wr_c7");
    run_op(1, 2'b01, 2'd3, 8'h00, 2, "rd_c7");
    run_op(1, 2'b11, 2'd3, 8'h00, 2, "clr_a3");
    check("clr_rdata1_kept", 32'(rdata1), 'hC7);
    run_op(0, 2'b01, 2'd3, 8'h00, 2, "rd_cleared");

    run_op(0, 2'b00, 2'd0, 8'h98, 2, "wr_98");
    run_op(0, 2'b01, 2'd0, 8'h00, 2, "rd_98");
    run_op(1, 2'b01, 2'd1, 8'h00, 2, "rd_other");
    check("isolation_rdata0", 32'(rdata0), 'h98);

    // Last grant went to requester 1, so requester 0 leads the alternation.
    ack_log.delete();
    fork
      begin
        for (int k = 0; k < 3; k++) run_op(0, 2'b10, 2'd0, 8'h00, -1, "alt_inc0");
      end
      begin
        for (int k = 0; k < 3; k++) run_op(1, 2'b10, 2'd1, 8'h00, -1, "alt_inc1");
      end
    join
    @(negedge clk);
    check("alt_count", 32'(ack_log.size()), 6);
    for (int i = 0; i < 6 && i < ack_log.size(); i++)
      check("alt_grant", 32'(ack_log[i]), 32'(i % 2));
    check("alt_rf0", 32'(rf_mem[0]), 'h9B);
    check("alt_rf1", 32'(rf_mem[1]), 'h03);

    // Reset during the write-back cycle of an INC.
    run_op(0, 2'b00, 2'd0, 8'h20, 2, "rst_pre_w");
    req_d[0]  = 1'b1;
    op_d[0]   = 2'b10;
    addr_d[0] = 2'd0;
    @(negedge clk);
    check("midrst_busy_exec", 32'(busy), 1);
    @(negedge clk);
    check("midrst_wb_wr_e", 32'(rf_wr_e), 1);
    check("midrst_wb_data", 32'(rf_wr_data), 'h21);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_wr_e", 32'(rf_wr_e), 0);
    check("midrst_wr_data", 32'(rf_wr_data), 0);
    check("midrst_ack0", 32'(ack0), 0);
    check("midrst_rdata0", 32'(rdata0), 0);
    check("midrst_rdata1", 32'(rdata1), 0);
    req_d[0]     = 1'b0;
    ref_rdata[0] = 8'h00;
    ref_rdata[1] = 8'h00;
    repeat (2) @(negedge clk);
    check("midrst_rf_kept", 32'(rf_mem[0]), 'h20);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Pointer returns to requester 0 after reset even though it was granted last.
    ack_log.delete();
    fork
      run_op(0, 2'b01, 2'd0, 8'h00, 2, "post_rst_rd0");
      run_op(1, 2'b01, 2'd2, 8'h00, 5, "post_rst_rd1");
    join
    check("post_rst_first", 32'(ack_log.size() > 0 ? ack_log[0] : 9), 0);
    check("sb_drained", 32'(sb0.size() + sb1.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
